// File: rtl/game_round_ctrl.sv
// Reaction-game round controller: seeds an external randomizer, lights one lamp, scores the player's flip.
// Hit/miss pulses 1 cycle after the deciding switch edge; waits indefinitely for rand_valid while rand_req is held.
module game_round_ctrl #(
  parameter int TIMEOUT  = 1000,
  parameter int ROUNDS   = 16,
  parameter int MAX_MISS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] switch,
  output logic       rand_req,
  output logic [8:0] seed,
  input  logic       rand_valid,
  input  logic [7:0] rand_value,
  output logic [7:0] light,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [7:0] round,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEED      = 3'd1;
  localparam logic [2:0] S_WAIT_RAND = 3'd2;
  localparam logic [2:0] S_ARMED     = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;
  localparam logic [2:0] S_OVER      = 3'd5;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ROUND_LIM  = 8'(ROUNDS);
  localparam logic [7:0]  MISS_LIM   = 8'(MAX_MISS);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [8:0]  r_token;
  logic [7:0]  r_switch_mem;
  logic [8:0]  r_seed;
  logic        r_rand_req;
  logic [7:0]  r_light;
  logic [15:0] r_timer;
  logic        r_hit;
  logic        r_miss;
  logic [7:0]  r_score;
  logic [7:0]  r_misses;
  logic [7:0]  r_round;

  logic [7:0]  w_changed;
  logic        w_start_game;
  logic        w_accept;
  logic        w_armed;
  logic        w_sw_hit;
  logic        w_sw_miss;
  logic        w_timeout;
  logic        w_decide_miss;
  logic [7:0]  w_round_nxt;
  logic [7:0]  w_misses_nxt;
  logic [7:0]  w_score_nxt;
  logic        w_game_end;
  logic        w_unused_rand;

  assign w_changed     = r_switch_mem ^ switch;
  assign w_start_game  = start && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_accept      = (r_state == S_WAIT_RAND) && r_rand_req && rand_valid;
  assign w_armed       = (r_state == S_ARMED);

  // Switch rule takes priority over timeout; any non-matching change (incl. multi-bit) is a miss.
  assign w_sw_hit      = w_armed && (w_changed == r_light);
  assign w_sw_miss     = w_armed && (w_changed != 8'd0) && (w_changed != r_light);
  assign w_timeout     = w_armed && (w_changed == 8'd0) && (r_timer == TIMER_LAST);
  assign w_decide_miss = w_sw_miss || w_timeout;

  // In RESULT, r_hit/r_miss record which counter this round advances.
  assign w_round_nxt   = r_round + 8'd1;
  assign w_score_nxt   = r_score + {7'd0, r_hit};
  assign w_misses_nxt  = r_misses + {7'd0, r_miss};
  assign w_game_end    = (w_round_nxt == ROUND_LIM) || (w_misses_nxt == MISS_LIM);

  assign w_unused_rand = ^rand_value[7:3];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_start_game) w_state_nxt = S_SEED;
      S_SEED:      w_state_nxt = S_WAIT_RAND;
      S_WAIT_RAND: if (w_accept) w_state_nxt = S_ARMED;
      S_ARMED:     if (w_sw_hit || w_decide_miss) w_state_nxt = S_RESULT;
      S_RESULT:    w_state_nxt = w_game_end ? S_OVER : S_SEED;
      S_OVER:      if (w_start_game) w_state_nxt = S_SEED;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_token      <= 9'd0;
      r_switch_mem <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_token      <= r_token + 9'd1;
      r_switch_mem <= switch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed     <= 9'd0;
      r_rand_req <= 1'b0;
    end else if (r_state == S_SEED) begin
      r_seed     <= r_token;
      r_rand_req <= 1'b1;
    end else if (w_accept) begin
      r_rand_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_light <= 8'd0;
    end else if (w_accept) begin
      r_light <= 8'd1 << rand_value[2:0];
    end else if (r_state == S_RESULT) begin
      r_light <= 8'd0;
    end
  end

  // Timer counts only while staying in ARMED; it reads 0 on every other cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 16'd0;
    end else if (w_armed && (w_state_nxt == S_ARMED)) begin
      r_timer <= r_timer + 16'd1;
    end else begin
      r_timer <= 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_hit  <= w_sw_hit;
      r_miss <= w_decide_miss;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score  <= 8'd0;
      r_misses <= 8'd0;
      r_round  <= 8'd0;
    end else if (w_start_game) begin
      r_score  <= 8'd0;
      r_misses <= 8'd0;
      r_round  <= 8'd0;
    end else if (r_state == S_RESULT) begin
      r_score  <= w_score_nxt;
      r_misses <= w_misses_nxt;
      r_round  <= w_round_nxt;
    end
  end

  assign rand_req  = r_rand_req;
  assign seed      = r_seed;
  assign light     = r_light;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign score     = r_score;
  assign misses    = r_misses;
  assign round     = r_round;
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with TIMEOUT=8, ROUNDS=4, MAX_MISS=3.
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] switch;
  logic       rand_req;
  logic [8:0] seed;
  logic       rand_valid;
  logic [7:0] rand_value;
  logic [7:0] light;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] round;
  logic       game_over;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] tm = 9'd0;
  logic [8:0] exp_seed;

  always #5 clk = ~clk;

  game_round_ctrl #(.TIMEOUT(8), .ROUNDS(4), .MAX_MISS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .switch     (switch),
    .rand_req   (rand_req),
    .seed       (seed),
    .rand_valid (rand_valid),
    .rand_value (rand_value),
    .light      (light),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .misses     (misses),
    .round      (round),
    .game_over  (game_over)
  );

  // Advance one clock; tm mirrors the free-running token as seen after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) tm = 9'd0;
    else     tm = tm + 9'd1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in SEED; plays one round answered with the correct flip.
  task automatic play_hit(input logic [7:0] rv, input logic [7:0] lt);
    tick();
    chk("ph_req_up", 16'(rand_req), 16'h1);
    rand_valid = 1'b1;
    rand_value = rv;
    tick();
    rand_valid = 1'b0;
    chk("ph_light", 16'(light), 16'(lt));
    chk("ph_req_down", 16'(rand_req), 16'h0);
    switch = switch ^ lt;
    tick();
    chk("ph_hit", 16'(hit), 16'h1);
    chk("ph_nomiss", 16'(miss), 16'h0);
    tick();
    chk("ph_hit_once", 16'(hit), 16'h0);
    chk("ph_light_clr", 16'(light), 16'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; switch = 8'h00; rand_valid = 1'b0; rand_value = 8'h00;
    tick();
    tick();
    chk("rst_req", 16'(rand_req), 16'h0);
    chk("rst_seed", 16'(seed), 16'h0);
    chk("rst_light", 16'(light), 16'h0);
    chk("rst_hit", 16'(hit), 16'h0);
    chk("rst_miss", 16'(miss), 16'h0);
    chk("rst_score", 16'(score), 16'h0);
    chk("rst_misses", 16'(misses), 16'h0);
    chk("rst_round", 16'(round), 16'h0);
    chk("rst_over", 16'(game_over), 16'h0);
    rst = 1'b0;

    // rand_valid with no request outstanding, and switch changes in IDLE
    rand_valid = 1'b1; rand_value = 8'h05;
    tick();
    rand_valid = 1'b0;
    chk("idle_rv_light", 16'(light), 16'h0);
    chk("idle_rv_req", 16'(rand_req), 16'h0);
    switch = 8'hFF;
    tick();
    chk("idle_sw_hit", 16'(hit), 16'h0);
    chk("idle_sw_miss", 16'(miss), 16'h0);
    tick();

    // Game 1
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_seed = tm;
    chk("seed_req_low", 16'(rand_req), 16'h0);
    tick();
    chk("wait_req", 16'(rand_req), 16'h1);
    chk("wait_seed", 16'(seed), 16'(exp_seed));
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_req", 16'(rand_req), 16'h1);
      chk("hold_seed", 16'(seed), 16'(exp_seed));
    end
    start = 1'b0;
    rand_valid = 1'b1; rand_value = 8'h05;
    tick();
    rand_valid = 1'b0;
    chk("g1r1_light", 16'(light), 16'h0020);
    chk("g1r1_req_drop", 16'(rand_req), 16'h0);
    switch = switch ^ 8'h20;
    tick();
    chk("g1r1_hit", 16'(hit), 16'h1);
    chk("g1r1_nomiss", 16'(miss), 16'h0);
    tick();
    chk("g1r1_hit_once", 16'(hit), 16'h0);
    chk("g1r1_score", 16'(score), 16'h1);
    chk("g1r1_round", 16'(round), 16'h1);
    chk("g1r1_light_clr", 16'(light), 16'h0);
    chk("g1r1_seed_state", 16'(rand_req), 16'h0);

    // Round 2: wrong single flip
    tick();
    chk("g1r2_req", 16'(rand_req), 16'h1);
    rand_valid = 1'b1; rand_value = 8'h00;
    tick();
    rand_valid = 1'b0;
    chk("g1r2_light", 16'(light), 16'h0001);
    switch = switch ^ 8'h08;
    tick();
    chk("g1r2_miss", 16'(miss), 16'h1);
    chk("g1r2_nohit", 16'(hit), 16'h0);
    tick();
    chk("g1r2_misses", 16'(misses), 16'h1);
    chk("g1r2_round", 16'(round), 16'h2);

    // Round 3: two bits flipped together, one of them the lit lamp
    tick();
    rand_valid = 1'b1; rand_value = 8'h02;
    tick();
    rand_valid = 1'b0;
    chk("g1r3_light", 16'(light), 16'h0004);
    switch = switch ^ 8'h14;
    tick();
    chk("g1r3_miss", 16'(miss), 16'h1);
    chk("g1r3_nohit", 16'(hit), 16'h0);
    tick();
    chk("g1r3_misses", 16'(misses), 16'h2);
    chk("g1r3_score", 16'(score), 16'h1);

    // Round 4: timeout, ends game on both limits
    tick();
    rand_valid = 1'b1; rand_value = 8'h07;
    tick();
    rand_valid = 1'b0;
    chk("g1r4_light", 16'(light), 16'h0080);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("g1r4_no_early_miss", 16'(miss), 16'h0);
    end
    chk("g1r4_light_held", 16'(light), 16'h0080);
    tick();
    chk("g1r4_tmo_miss", 16'(miss), 16'h1);
    tick();
    chk("g1_over", 16'(game_over), 16'h1);
    chk("g1_misses", 16'(misses), 16'h3);
    chk("g1_round", 16'(round), 16'h4);
    chk("g1_score", 16'(score), 16'h1);
    switch = switch ^ 8'hFF;
    rand_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("over_hold_over", 16'(game_over), 16'h1);
      chk("over_hold_misses", 16'(misses), 16'h3);
      chk("over_hold_score", 16'(score), 16'h1);
      chk("over_hold_req", 16'(rand_req), 16'h0);
      chk("over_hold_pulse", 16'({hit, miss}), 16'h0);
    end
    rand_valid = 1'b0;

    // Game 2: restart from OVER, tie on round 1, then run to ROUNDS
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("g2_clr_score", 16'(score), 16'h0);
    chk("g2_clr_misses", 16'(misses), 16'h0);
    chk("g2_clr_round", 16'(round), 16'h0);
    chk("g2_clr_over", 16'(game_over), 16'h0);
    tick();
    chk("g2_req", 16'(rand_req), 16'h1);
    rand_valid = 1'b1; rand_value = 8'h03;
    tick();
    rand_valid = 1'b0;
    chk("g2r1_light", 16'(light), 16'h0008);
    for (int i = 0; i < 7; i++) tick();
    switch = switch ^ 8'h08;
    tick();
    chk("tie_hit", 16'(hit), 16'h1);
    chk("tie_nomiss", 16'(miss), 16'h0);
    tick();
    chk("tie_score", 16'(score), 16'h1);
    chk("tie_misses", 16'(misses), 16'h0);
    play_hit(8'h9E, 8'h40);
    play_hit(8'h01, 8'h02);
    play_hit(8'hF8, 8'h01);
    chk("g2_over", 16'(game_over), 16'h1);
    chk("g2_score", 16'(score), 16'h4);
    chk("g2_round", 16'(round), 16'h4);
    chk("g2_misses", 16'(misses), 16'h0);

    // Game 3: reset in WAIT_RAND with counters nonzero
    start = 1'b1;
    tick();
    start = 1'b0;
    play_hit(8'h02, 8'h04);
    chk("g3_score", 16'(score), 16'h1);
    tick();
    chk("g3_req", 16'(rand_req), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req", 16'(rand_req), 16'h0);
    chk("rw_seed", 16'(seed), 16'h0);
    chk("rw_score", 16'(score), 16'h0);
    chk("rw_round", 16'(round), 16'h0);
    chk("rw_light", 16'(light), 16'h0);
    chk("rw_over", 16'(game_over), 16'h0);
    tick();
    chk("rw_idle", 16'(rand_req), 16'h0);
    switch = switch ^ 8'h55;
    tick();
    chk("rw_sw_pulse", 16'({hit, miss}), 16'h0);
    tick();
    chk("rw_still_idle", 16'(rand_req), 16'h0);

    // Reset in ARMED
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rand_valid = 1'b1; rand_value = 8'h01;
    tick();
    rand_valid = 1'b0;
    chk("ra_light", 16'(light), 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_light_clr", 16'(light), 16'h0);
    chk("ra_req", 16'(rand_req), 16'h0);
    chk("ra_pulse", 16'({hit, miss}), 16'h0);
    switch = switch ^ 8'h02;
    tick();
    chk("ra_sw_pulse", 16'({hit, miss}), 16'h0);
    tick();
    chk("ra_sw_pulse2", 16'({hit, miss}), 16'h0);
    chk("ra_idle", 16'(rand_req), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
